// File: rtl/write_port_arbiter.sv
// write_port_arbiter: shares the register-file write port between writeback and a buffered multiply/divide source
// Ports: WPA_CLK/WPA_RST clock and async active-high reset; WPA_ResultW/WriteRegW/RegWriteW writeback request;
// WPA_MdValid/MdData/MdReg/MdReady multiply/divide handshake; WPA_RfWE/RfAddr/RfData register-file write;
// WPA_StallW forced one-cycle pipeline stall; WPA_Busy pending buffer not empty.
// Optional macro WPA_BYPASS_EN: an idle port lets an accepted result write in the same cycle without buffering.
module write_port_arbiter #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             WPA_CLK,
  input  logic             WPA_RST,
  input  logic [WIDTH-1:0] WPA_ResultW,
  input  logic [4:0]       WPA_WriteRegW,
  input  logic             WPA_RegWriteW,
  input  logic             WPA_MdValid,
  input  logic [WIDTH-1:0] WPA_MdData,
  input  logic [4:0]       WPA_MdReg,
  output logic             WPA_MdReady,
  output logic             WPA_RfWE,
  output logic [4:0]       WPA_RfAddr,
  output logic [WIDTH-1:0] WPA_RfData,
  output logic             WPA_StallW,
  output logic             WPA_Busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH+4:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [3:0] starve;
  logic nonempty, wb_req, accept, bypass, push, pop;
  logic [WIDTH+4:0] head;
  assign head = mem[rd_ptr];
  assign nonempty = count != '0;
  // Gated by reset so the combinational writeback path is silent while WPA_RST is high.
  assign wb_req = WPA_RegWriteW && WPA_WriteRegW != 5'd0 && !WPA_RST;
  assign WPA_MdReady = !WPA_RST && count < CW'(DEPTH);
  assign WPA_StallW = starve == 4'(STARVE_LIMIT) && nonempty;
  assign WPA_Busy = nonempty;
  // Results to register 0 complete the handshake but are dropped.
  assign accept = WPA_MdValid && WPA_MdReady && WPA_MdReg != 5'd0;
  // During a stall the held W stage re-presents its request, so the head wins.
  assign pop = nonempty && (WPA_StallW || !wb_req);
`ifdef WPA_BYPASS_EN
  assign bypass = accept && !nonempty && !wb_req;
`else
  assign bypass = 1'b0;
`endif
  assign push = accept && !bypass;
  always_comb begin
    WPA_RfWE = pop || wb_req || bypass;
    WPA_RfAddr = pop ? head[WIDTH+4:WIDTH] : wb_req ? WPA_WriteRegW : bypass ? WPA_MdReg : 5'd0;
    WPA_RfData = pop ? head[WIDTH-1:0] : wb_req ? WPA_ResultW : bypass ? WPA_MdData : '0;
  end
  always_ff @(posedge WPA_CLK) begin
    if (push) mem[wr_ptr] <= {WPA_MdReg, WPA_MdData};
  end
  always_ff @(posedge WPA_CLK or posedge WPA_RST) begin
    if (WPA_RST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      starve <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
      // A non-popping cycle with a non-empty buffer means writeback took the port.
      starve <= (pop || !nonempty) ? 4'd0 : starve + 4'd1;
    end
  end
endmodule

// File: tb/tb_write_port_arbiter.sv
// tb_write_port_arbiter: scoreboard bench for write_port_arbiter
module tb_write_port_arbiter;
  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [WIDTH-1:0] result_w = '0, md_data = '0;
  logic [4:0] write_reg_w = '0, md_reg = '0;
  logic reg_write_w = 1'b0, md_valid = 1'b0;
  logic md_ready, rf_we, stall_w, busy;
  logic [4:0] rf_addr;
  logic [WIDTH-1:0] rf_data;
  logic [WIDTH+4:0] sb [$];
  int m_starve = 0;
  int checks = 0;
  int errors = 0;
  write_port_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .WPA_CLK(clk), .WPA_RST(rst), .WPA_ResultW(result_w), .WPA_WriteRegW(write_reg_w),
    .WPA_RegWriteW(reg_write_w), .WPA_MdValid(md_valid), .WPA_MdData(md_data), .WPA_MdReg(md_reg),
    .WPA_MdReady(md_ready), .WPA_RfWE(rf_we), .WPA_RfAddr(rf_addr), .WPA_RfData(rf_data),
    .WPA_StallW(stall_w), .WPA_Busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic rw, input logic [4:0] wr, input logic [WIDTH-1:0] wd,
                     input logic mv, input logic [4:0] mr, input logic [WIDTH-1:0] md, output logic acc);
    int sz;
    logic st, rdy, wbq, bp, popped, exp_we;
    logic [WIDTH+4:0] exp_w;
    @(negedge clk);
    reg_write_w = rw; write_reg_w = wr; result_w = wd;
    md_valid = mv; md_reg = mr; md_data = md;
    #2;
    sz = sb.size();
    st = m_starve == LIMIT && sz > 0;
    rdy = sz < DEPTH;
    wbq = rw && wr != 5'd0;
    acc = mv && rdy;
    bp = 1'b0;
`ifdef WPA_BYPASS_EN
    bp = acc && mr != 5'd0 && sz == 0 && !wbq;
`endif
    popped = 1'b0;
    exp_we = 1'b1;
    if (sz > 0 && (st || !wbq)) begin
      exp_w = sb.pop_front();
      popped = 1'b1;
    end else if (wbq) exp_w = {wr, wd};
    else if (bp) exp_w = {mr, md};
    else begin
      exp_we = 1'b0;
      exp_w = '0;
    end
    check("stall", stall_w, st);
    check("ready", md_ready, rdy);
    check("busy", busy, sz > 0);
    check("we", rf_we, exp_we);
    check("addr", rf_addr, exp_w[WIDTH+4:WIDTH]);
    check("data", rf_data, exp_w[WIDTH-1:0]);
    if (acc && mr != 5'd0 && !bp) sb.push_back({mr, md});
    m_starve = (popped || sz == 0) ? 0 : m_starve + 1;
  endtask
  initial begin
    logic a;
    int n_stall;
    logic [4:0] stall_addr;
    logic first_acc, we0;
    #2;
    check("rst_we", rf_we, 1'b0);
    check("rst_ready", md_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) cyc(0, 0, 0, 0, 0, 0, a);
    cyc(1, 5'd8, 32'h12345678, 0, 0, 0, a);
    check("wb_only_addr", rf_addr, 5'd8);
    for (int i = 0; i < 4; i++) cyc(1, 5'(i + 1), $urandom, 0, 0, 0, a);
    n_stall = 0;
    stall_addr = '0;
    cyc(1, 5'd8, $urandom, 1, 5'd9, 32'hCAFE0001, a);
    for (int i = 0; i < 9; i++) begin
      cyc(1, 5'd8, $urandom, 0, 0, 0, a);
      if (stall_w) begin
        n_stall++;
        stall_addr = rf_addr;
      end
    end
    check("stall_once", n_stall, 1);
    check("stall_addr", stall_addr, 5'd9);
    check("busy_after", busy, 1'b0);
    cyc(1, 5'd6, $urandom, 1, 5'd3, 32'h33, a);
    cyc(1, 5'd6, $urandom, 1, 5'd4, 32'h44, a);
    first_acc = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(1, 5'd6, $urandom, 1, 5'd5, 32'h55, a);
      if (i == 0) first_acc = a;
      if (a) break;
    end
    check("full_refuse", first_acc, 1'b0);
    check("reg5_accepted", a, 1'b1);
    for (int i = 0; i < 8; i++) cyc(i[0], 5'd12, $urandom, 0, 0, 0, a);
    check("drained", sb.size(), 0);
    cyc(1, 5'd0, 32'hDEAD, 0, 0, 0, a);
    check("r0_wb_we", rf_we, 1'b0);
    cyc(0, 0, 0, 1, 5'd0, 32'hBAD0, a);
    check("r0_md_acc", a, 1'b1);
    cyc(0, 0, 0, 0, 0, 0, a);
    check("r0_md_busy", busy, 1'b0);
    check("r0_md_we", rf_we, 1'b0);
    cyc(0, 0, 0, 1, 5'd7, 32'h0000BEEF, a);
    we0 = rf_we;
`ifdef WPA_BYPASS_EN
    check("bypass_same", we0, 1'b1);
`else
    check("bypass_same", we0, 1'b0);
    cyc(0, 0, 0, 0, 0, 0, a);
    check("bypass_next_addr", rf_addr, 5'd7);
`endif
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, a);
    for (int i = 0; i < 40; i++)
      cyc($urandom_range(0, 1), 5'($urandom), $urandom, $urandom_range(0, 1), 5'($urandom), $urandom, a);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 0, 0, a);
    cyc(1, 5'd8, $urandom, 1, 5'd10, 32'hA0, a);
    cyc(1, 5'd8, $urandom, 1, 5'd11, 32'hB0, a);
    cyc(1, 5'd8, $urandom, 0, 0, 0, a);
    check("pre_rst_busy", busy, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_we", rf_we, 1'b0);
    check("mid_rst_addr", rf_addr, 5'd0);
    check("mid_rst_data", rf_data, 32'd0);
    check("mid_rst_ready", md_ready, 1'b0);
    check("mid_rst_stall", stall_w, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    sb.delete();
    m_starve = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0, 0, a);
    cyc(0, 0, 0, 1, 5'd13, 32'hD0, a);
    check("post_rst_acc", a, 1'b1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, a);
    check("final_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
